// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches over a req/ack bus into a prefetch buffer that feeds decode.
// Optional macro ARVI_IFU_BYPASS_EN forwards an ack straight to decode when the buffer is empty.
`timescale 1ns/1ps
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_Stall,
  input  logic        i_Redirect,
  input  logic [31:0] i_Redirect_PC,
  output logic [31:0] o_Instr,
  output logic [31:0] o_PC,
  output logic        o_Valid,
  output logic        o_Fetch_err,
  output logic        o_IBus_req,
  output logic [31:0] o_IBus_addr,
  input  logic        i_IBus_ack,
  input  logic [31:0] i_IBus_rdata,
  input  logic        i_IBus_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] mem_instr_q [FIFO_DEPTH];
  logic [31:0] mem_pc_q    [FIFO_DEPTH];
  logic        mem_err_q   [FIFO_DEPTH];

  logic        ack_s, empty_s, byp_s, valid_s, pop_s, buf_pop_s, push_s;
  logic [31:0] head_instr_s, head_pc_s, aligned_pc_s;
  logic        head_err_s;

  // req_q doubles as the single-outstanding flag, so a completion is req_q & ack
  assign ack_s        = req_q & i_IBus_ack;
  assign empty_s      = (cnt_q == {CNT_W{1'b0}});
  assign aligned_pc_s = i_Redirect_PC & 32'hFFFF_FFFC;

`ifdef ARVI_IFU_BYPASS_EN
  assign byp_s = empty_s & ack_s & ~i_Redirect;
`else
  assign byp_s = 1'b0;
`endif

  assign valid_s   = ~empty_s | byp_s;
  assign pop_s     = valid_s & ~i_Stall & ~i_Redirect;
  assign buf_pop_s = pop_s & ~empty_s;
  assign push_s    = ack_s & ~i_Redirect & ~(byp_s & ~i_Stall);

  // Head entry selection: bypassed bus data or buffer head
  always_comb begin
    head_instr_s = mem_instr_q[rd_ptr_q];
    head_pc_s    = mem_pc_q[rd_ptr_q];
    head_err_s   = mem_err_q[rd_ptr_q];
    if (byp_s) begin
      head_instr_s = i_IBus_rdata;
      head_pc_s    = pc_q;
      head_err_s   = i_IBus_err;
    end else begin
      head_instr_s = mem_instr_q[rd_ptr_q];
      head_pc_s    = mem_pc_q[rd_ptr_q];
      head_err_s   = mem_err_q[rd_ptr_q];
    end
  end

  assign o_Valid     = valid_s;
  assign o_Fetch_err = valid_s & head_err_s;
  assign o_Instr     = (valid_s & ~head_err_s) ? head_instr_s : NOP;
  assign o_PC        = valid_s ? head_pc_s : pc_q;
  assign o_IBus_req  = req_q;
  assign o_IBus_addr = pc_q;

  // Next-state: buffer bookkeeping, fetch PC and request FSM
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (i_Redirect) begin
      cnt_d    = {CNT_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      pc_d     = aligned_pc_s;
    end else begin
      cnt_d    = cnt_q + CNT_W'(push_s) - CNT_W'(buf_pop_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(buf_pop_s);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      if (ack_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (i_Redirect) begin
          // An unacked request cannot be recalled; its late ack must be swallowed
          if (req_q && !i_IBus_ack) begin
            state_d = ST_DISCARD;
            req_d   = 1'b0;
          end else begin
            state_d = ST_RUN;
            req_d   = 1'b1;
          end
        end else if (ack_s && i_IBus_err) begin
          state_d = ST_HALT;
          req_d   = 1'b0;
        end else if (req_q && !ack_s) begin
          req_d = 1'b1;
        end else begin
          req_d = (cnt_d < DEPTH_C);
        end
      end
      ST_DISCARD: begin
        if (i_IBus_ack) begin
          state_d = ST_RUN;
          req_d   = (cnt_d < DEPTH_C);
        end else begin
          state_d = ST_DISCARD;
          req_d   = 1'b0;
        end
      end
      ST_HALT: begin
        if (i_Redirect) begin
          state_d = ST_RUN;
          req_d   = 1'b1;
        end else begin
          state_d = ST_HALT;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUN;
        req_d   = 1'b0;
      end
    endcase
  end

  // Control state registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_RUN;
      req_q    <= 1'b0;
      pc_q     <= RESET_PC;
      cnt_q    <= {CNT_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Prefetch buffer storage; contents are qualified by cnt_q so need no reset
  always_ff @(posedge i_clk) begin
    if (push_s && !i_rst) begin
      mem_instr_q[wr_ptr_q] <= i_IBus_rdata;
      mem_pc_q[wr_ptr_q]    <= pc_q;
      mem_err_q[wr_ptr_q]   <= i_IBus_err;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal expectations,
// then randomized bus/stall/redirect/reset traffic checked every cycle against a queue model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef ARVI_IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        ack = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        err = 1'b0;
  logic [31:0] o_instr, o_pc, o_addr;
  logic        o_valid, o_ferr, o_req;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_Stall(stall), .i_Redirect(redir), .i_Redirect_PC(rpc),
    .o_Instr(o_instr), .o_PC(o_pc), .o_Valid(o_valid), .o_Fetch_err(o_ferr),
    .o_IBus_req(o_req), .o_IBus_addr(o_addr),
    .i_IBus_ack(ack), .i_IBus_rdata(rdata), .i_IBus_err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } ent_t;

  // Reference model: buffered entries, fetch mode (0 run, 1 discard, 2 halt), request flag, fetch PC
  ent_t        q[$];
  int          mode;
  bit          m_req;
  logic [31:0] m_pc;
  bit          m_init = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit   byp, v, popped, got;
    ent_t h, e;
    byp = BYP && (q.size() == 0) && m_req && ack && !redir;
    v   = byp || (q.size() > 0);
    h   = '0;
    if (byp) h = '{instr: rdata, pc: m_pc, err: err};
    else if (q.size() > 0) h = q[0];
    if (m_init) begin
      chk("valid", 32'(o_valid), 32'(v));
      chk("req", 32'(o_req), 32'(m_req));
      if (m_req) chk("addr", o_addr, m_pc);
      if (v) begin
        chk("ferr", 32'(o_ferr), 32'(h.err));
        chk("instr", o_instr, h.err ? NOP : h.instr);
        chk("pc", o_pc, h.pc);
      end else begin
        chk("instr_nop", o_instr, NOP);
      end
    end
    if (rst) begin
      q.delete();
      mode   = 0;
      m_req  = 1'b0;
      m_pc   = RESET_PC;
      m_init = 1'b1;
      return;
    end
    if (redir) begin
      q.delete();
      if (mode == 0 && m_req && !ack) begin
        mode  = 1;
        m_req = 1'b0;
      end else if (mode == 1 && !ack) begin
        m_req = 1'b0;
      end else begin
        mode  = 0;
        m_req = 1'b1;
      end
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      got    = m_req && ack;
      popped = v && !stall;
      if (popped && q.size() > 0) void'(q.pop_front());
      if (got) begin
        e = '{instr: rdata, pc: m_pc, err: err};
        if (!(byp && popped)) q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
      if (got && err) begin
        mode  = 2;
        m_req = 1'b0;
      end else if (mode == 1 && ack) begin
        mode  = 0;
        m_req = (q.size() < DEPTH);
      end else if (mode == 0) begin
        m_req = (m_req && !got) || (q.size() < DEPTH);
      end else begin
        m_req = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive inputs just after the edge, then check and advance the model
  task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] rp,
                      input bit a, input bit e, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = r; stall = s; redir = rd; rpc = rp; ack = a; err = e; rdata = d;
    #3;
    model_step();
  endtask

  task automatic cyc(input bit s, input bit rd, input logic [31:0] rp,
                     input bit a, input bit e, input logic [31:0] d);
    step(1'b0, s, rd, rp, a, e, d);
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("L_rst_req", 32'(o_req), 32'h0);
    chk("L_rst_valid", 32'(o_valid), 32'h0);
    chk("L_rst_pc", o_pc, 32'h8000_0000);
    chk("L_rst_instr", o_instr, 32'h0000_0013);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("L_rel_req", 32'(o_req), 32'h0);

    // Ack every cycle, words A, B, C
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0A13);
    chk("L_c1_addr", o_addr, 32'h8000_0000);
    chk("L_c1_valid", 32'(o_valid), 32'(BYP));
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0B13);
    chk("L_c2_addr", o_addr, 32'h8000_0004);
    chk("L_c2_instr", o_instr, BYP ? 32'h0000_0B13 : 32'h0000_0A13);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0C13);
    chk("L_c3_addr", o_addr, 32'h8000_0008);
    chk("L_c3_instr", o_instr, BYP ? 32'h0000_0C13 : 32'h0000_0B13);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("L_c4_instr", o_instr, BYP ? 32'h0000_0013 : 32'h0000_0C13);

    // Stall for 5 cycles: buffer fills to 2, request drops, head frozen
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0D13);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0E13);
    chk("L_s2_instr", o_instr, 32'h0000_0D13);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("L_s5_req", 32'(o_req), 32'h0);
    chk("L_s5_instr", o_instr, 32'h0000_0D13);
    chk("L_s5_pc", o_pc, 32'h8000_000C);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("L_r1_instr", o_instr, 32'h0000_0D13);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("L_r2_instr", o_instr, 32'h0000_0E13);
    chk("L_r2_pc", o_pc, 32'h8000_0010);
    chk("L_r2_addr", o_addr, 32'h8000_0014);

    // Redirect to 0x100 with a request pending; stale ack two cycles later
    cyc(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("L_d1_req", 32'(o_req), 32'h0);
    chk("L_d1_valid", 32'(o_valid), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("L_d2_valid", 32'(o_valid), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0F13);
    chk("L_d3_addr", o_addr, 32'h0000_0100);
    chk("L_d3_valid", 32'(o_valid), 32'(BYP));

    // Redirect and ack in the same cycle to 0x203
    cyc(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1'b0, 32'hBAD0_0013);
    cyc(1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0213);
    chk("L_d5_valid", 32'(o_valid), 32'h0);
    chk("L_d5_req", 32'(o_req), 32'h1);
    chk("L_d5_addr", o_addr, 32'h0000_0200);

    // Bus error on fetch of 0x10
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1234_5678);
    chk("L_e_addr", o_addr, 32'h0000_0010);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("L_e_valid", 32'(o_valid), 32'h1);
    chk("L_e_ferr", 32'(o_ferr), 32'h1);
    chk("L_e_instr", o_instr, 32'h0000_0013);
    chk("L_e_pc", o_pc, 32'h0000_0010);
    chk("L_e_req", 32'(o_req), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("L_h_req", 32'(o_req), 32'h0);
    chk("L_h_valid", 32'(o_valid), 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0);
    chk("L_h2_req", 32'(o_req), 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0413);
    chk("L_h_restart", o_addr, 32'h0000_0040);
    chk("L_h_restart_req", 32'(o_req), 32'h1);

    // Reset with a full buffer
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0513);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("L_full_instr", o_instr, 32'h0000_0413);
    chk("L_full_req", 32'(o_req), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("L_rr_req", 32'(o_req), 32'h0);
    chk("L_rr_valid", 32'(o_valid), 32'h0);
    chk("L_rr_pc", o_pc, 32'h8000_0000);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("L_rr_addr", o_addr, 32'h8000_0000);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit          r, s, rd, a, e;
      logic [31:0] rp, d;
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 29) == 0);
      rp = $urandom & 32'h8000_0FFF;
      d  = $urandom;
      a  = 1'b0;
      if (!r) begin
        if (m_req) a = ($urandom_range(0, 9) < 6);
        else if (mode == 1) a = ($urandom_range(0, 9) < 4);
      end
      e = a && ($urandom_range(0, 15) == 0);
      step(r, s, rd, rp, a, e, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
